core_axil_read_arbiter: RTL and testbench
=========================================

# core_axil_read_arbiter

Two-requester AXI-lite read arbiter that shares the core's single memory read port between the instruction fetch stage and the load/store unit. It sits between the core-side read masters and the SoC memory interconnect. It serialises requests so that at most one transaction is in flight, latches the winning address, and routes the read data back to the granted requester.

## Interface
Parameters:
- ADDR_WIDTH, core_pkg::ADDR_WIDTH, read address width
- DATA_WIDTH, core_pkg::DATA_WIDTH, read data width

Ports. Index 0 is instruction fetch (`if_*`); index 1 is data/load (`ls_*`):
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- if_ARADDR  in  ADDR_WIDTH  fetch read address
- if_ARVALID  in  1  fetch address valid
- if_ARREADY  out  1  fetch address accepted
- if_RDATA  out  DATA_WIDTH  fetch read data
- if_RVALID  out  1  fetch read data valid
- if_RREADY  in  1  fetch ready for data
- ls_ARADDR / ls_ARVALID / ls_ARREADY / ls_RDATA / ls_RVALID / ls_RREADY: same as the `if_*` ports, for the load/store unit
- m_ARADDR  out  ADDR_WIDTH  downstream read address (registered)
- m_ARVALID  out  1  downstream address valid (registered)
- m_ARREADY  in  1  downstream address accepted
- m_RDATA  in  DATA_WIDTH  downstream read data
- m_RVALID  in  1  downstream data valid
- m_RREADY  out  1  downstream data ready

## Operation
FSM states: IDLE, ADDR, DATA. Reset state is IDLE.

- **IDLE**
  - Arbitrate among the asserted ARVALIDs.
  - Assert the winner's ARREADY combinationally in this cycle.
  - On the clock edge: latch the winner's ARADDR into m_ARADDR, record `grant` (0 = fetch, 1 = load/store), set m_ARVALID=1, go to ADDR.
  - With no requests: stay in IDLE, all ARREADY=0.
- **ADDR**
  - Hold m_ARVALID=1 and keep m_ARADDR stable.
  - On m_ARREADY=1: clear m_ARVALID and go to DATA.
  - Both upstream ARREADYs are 0.
- **DATA**
  - Route data to the granted requester: its RVALID = m_RVALID and its RDATA = m_RDATA.
  - m_RREADY = the granted requester's RREADY.
  - The non-granted requester sees RVALID=0 and RDATA=0.
  - On m_RVALID & m_RREADY: update the priority pointer and go to IDLE.
- **Arbitration**
  - Chosen by the configuration macro (see Configuration).
  - Evaluated only in IDLE. A request arriving during ADDR or DATA waits.
  - Requesters must hold ARVALID/ARADDR until their ARREADY, per AXI.
- **Simultaneous events**
  - A request arriving in the same cycle the FSM enters IDLE is arbitrated in that IDLE cycle.
  - There is no DATA→ADDR bypass.
- **Outstanding transactions:** one at most. Every response belongs to `grant`.
- **Reset mid-transaction**
  - FSM returns to IDLE; the transaction is dropped.
  - Downstream is reset by the same rst, so no orphan response is expected.

Reset values of all registered outputs:
- m_ARVALID=0, m_ARADDR=0, grant=0, priority pointer=0 (fetch preferred first).

Outputs in IDLE, including immediately after reset:
- if_ARREADY=0 and ls_ARREADY=0 unless a request is present.
- All RVALID=0, RDATA=0, m_RREADY=0.

## Timing
- Upstream AR handshake at cycle T (IDLE) → m_ARVALID=1 at T+1.
- m_ARREADY at cycle A (A ≥ T+1) → FSM is in DATA from A+1.
- Response handshake at cycle D → FSM is in IDLE at D+1; the next grant handshake can occur at D+1.
- Minimum transaction: 3 cycles (IDLE, ADDR with immediate ARREADY, DATA with immediate RVALID).
- Back-to-back throughput: one read per 3 cycles.
- Combinational paths:
  - ARVALID → ARREADY (IDLE only)
  - m_RVALID/m_RDATA → requester RVALID/RDATA
  - requester RREADY → m_RREADY
- No combinational path from m_ARREADY to any upstream output.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration. After a completed response, the pointer moves to the other requester.
  - Under contention, grants alternate fetch, load, fetch, …
- Undefined:
  - Fixed priority: load/store always wins over fetch when both are valid.
  - The pointer register is removed.

## Structure
- core_pkg adds `typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} arb_state_t;` and `localparam ARB_REQ_NUM = 2;`.
- Sub-module `core_arb_picker` (combinational):
  - Inputs: req[1:0] and the pointer. Output: one-hot gnt[1:0].
  - Contains both arbitration policies under the macro.
  - The FSM and routing stay in the top module.

## Test plan
1. Single fetch: if_ARADDR=0x100 held, m_ARREADY=1, m_RVALID=1 with m_RDATA=0x00000013 one cycle later → if_RVALID=1, if_RDATA=0x13, ls_RVALID=0; IDLE after 3 cycles.
2. Contention with macro defined: both requesters valid continuously (addresses 0x200 and 0x800) → m_ARADDR sequence 0x200, 0x800, 0x200, 0x800.
3. Contention with macro undefined: both requesters valid for 4 transactions → m_ARADDR = ls address every time; if_ARREADY stays 0.
4. Slave backpressure: m_ARREADY low for 5 cycles → m_ARVALID stays 1 and m_ARADDR stays constant; no upstream ARREADY during the wait.
5. Requester backpressure: if_RREADY=0 for 3 cycles while m_RVALID=1 → m_RREADY=0 and the FSM stays in DATA; it completes on the first cycle with if_RREADY=1.
6. Reset asserted in ADDR and in DATA → asynchronous return to IDLE with m_ARVALID=0 and all RVALID=0, before the next clock edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: bus widths plus the read-arbiter state encoding.
// Purely declarative; no logic and no flow control here.
package core_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int ARB_REQ_NUM = 2;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_t;

endpackage

// File: rtl/core_arb_picker.sv
// One-hot grant picker for the read arbiter (bit 0 fetch, bit 1 load/store); purely combinational, zero latency.
// No backpressure of its own; ARB_ROUND_ROBIN_EN selects pointer-based round-robin, otherwise load/store has fixed priority.
module core_arb_picker
    import core_pkg::*;
(
    input  logic [ARB_REQ_NUM-1:0] i_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic                   i_ptr,
`endif
    output logic [ARB_REQ_NUM-1:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
`ifdef ARB_ROUND_ROBIN_EN
        // i_ptr names the requester preferred on a tie
        if (i_ptr) begin
            if (i_req[1])      o_gnt = 2'b10;
            else if (i_req[0]) o_gnt = 2'b01;
        end else begin
            if (i_req[0])      o_gnt = 2'b01;
            else if (i_req[1]) o_gnt = 2'b10;
        end
`else
        if (i_req[1])      o_gnt = 2'b10;
        else if (i_req[0]) o_gnt = 2'b01;
`endif
    end

endmodule

// File: rtl/core_axil_read_arbiter.sv
// Shares one AXI-lite read port between fetch (0) and load/store (1); one read in flight, 3 cycles minimum per read.
// ARREADY is offered only in IDLE and the R channel passes RREADY straight through; ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module core_axil_read_arbiter #(
    parameter int ADDR_WIDTH = core_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] if_ARADDR,
    input  logic                  if_ARVALID,
    output logic                  if_ARREADY,
    output logic [DATA_WIDTH-1:0] if_RDATA,
    output logic                  if_RVALID,
    input  logic                  if_RREADY,

    input  logic [ADDR_WIDTH-1:0] ls_ARADDR,
    input  logic                  ls_ARVALID,
    output logic                  ls_ARREADY,
    output logic [DATA_WIDTH-1:0] ls_RDATA,
    output logic                  ls_RVALID,
    input  logic                  ls_RREADY,

    output logic [ADDR_WIDTH-1:0] m_ARADDR,
    output logic                  m_ARVALID,
    input  logic                  m_ARREADY,
    input  logic [DATA_WIDTH-1:0] m_RDATA,
    input  logic                  m_RVALID,
    output logic                  m_RREADY
);

    import core_pkg::*;

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic                    r_grant;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic                    r_arvalid;
    logic [ARB_REQ_NUM-1:0]  w_req;
    logic [ARB_REQ_NUM-1:0]  w_gnt;
    logic                    w_ar_hs;
    logic                    w_r_hs;

    assign w_req = {ls_ARVALID, if_ARVALID};

`ifdef ARB_ROUND_ROBIN_EN
    logic r_ptr;

    core_arb_picker u_picker (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    // After each completed read the other requester gets the tie-break
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= 1'b0;
        end else if (w_r_hs) begin
            r_ptr <= ~r_grant;
        end
    end
`else
    core_arb_picker u_picker (
        .i_req (w_req),
        .o_gnt (w_gnt)
    );
`endif

    assign w_r_hs = (r_state == ARB_DATA) && m_RVALID && m_RREADY;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ar_hs     = 1'b0;
        if_ARREADY  = 1'b0;
        ls_ARREADY  = 1'b0;
        if_RVALID   = 1'b0;
        if_RDATA    = '0;
        ls_RVALID   = 1'b0;
        ls_RDATA    = '0;
        m_RREADY    = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if_ARREADY = w_gnt[0];
                ls_ARREADY = w_gnt[1];
                if (|w_gnt) begin
                    w_ar_hs     = 1'b1;
                    w_state_nxt = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (m_ARREADY) begin
                    w_state_nxt = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (r_grant) begin
                    ls_RVALID = m_RVALID;
                    ls_RDATA  = m_RDATA;
                    m_RREADY  = ls_RREADY;
                end else begin
                    if_RVALID = m_RVALID;
                    if_RDATA  = m_RDATA;
                    m_RREADY  = if_RREADY;
                end
                if (w_r_hs) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Winner's address is captured so the requester may move on immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_araddr  <= '0;
            r_arvalid <= 1'b0;
            r_grant   <= 1'b0;
        end else if (w_ar_hs) begin
            r_araddr  <= w_gnt[1] ? ls_ARADDR : if_ARADDR;
            r_grant   <= w_gnt[1];
            r_arvalid <= 1'b1;
        end else if ((r_state == ARB_ADDR) && m_ARREADY) begin
            r_arvalid <= 1'b0;
        end
    end

    assign m_ARADDR  = r_araddr;
    assign m_ARVALID = r_arvalid;

endmodule

// File: tb/tb_core_axil_read_arbiter.sv
// Bench for core_axil_read_arbiter: vector table, hand-written corner sequences and a randomized scoreboard run.
module tb_core_axil_read_arbiter;
    import core_pkg::*;

    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] if_ARADDR = '0, ls_ARADDR = '0, m_ARADDR;
    logic          if_ARVALID = 1'b0, ls_ARVALID = 1'b0, if_ARREADY, ls_ARREADY;
    logic [DW-1:0] if_RDATA, ls_RDATA, m_RDATA = '0;
    logic          if_RVALID, ls_RVALID, if_RREADY = 1'b0, ls_RREADY = 1'b0;
    logic          m_ARVALID, m_ARREADY = 1'b0, m_RVALID = 1'b0, m_RREADY;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_axil_read_arbiter dut (
        .clk(clk), .rst(rst_n),
        .if_ARADDR(if_ARADDR), .if_ARVALID(if_ARVALID), .if_ARREADY(if_ARREADY),
        .if_RDATA(if_RDATA), .if_RVALID(if_RVALID), .if_RREADY(if_RREADY),
        .ls_ARADDR(ls_ARADDR), .ls_ARVALID(ls_ARVALID), .ls_ARREADY(ls_ARREADY),
        .ls_RDATA(ls_RDATA), .ls_RVALID(ls_RVALID), .ls_RREADY(ls_RREADY),
        .m_ARADDR(m_ARADDR), .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
        .m_RDATA(m_RDATA), .m_RVALID(m_RVALID), .m_RREADY(m_RREADY)
    );

    typedef struct {
        logic          sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        int            ar_wait;
        int            r_wait;
        logic [AW-1:0] exp_addr;
        logic          exp_if_v;
        logic          exp_ls_v;
        logic [DW-1:0] exp_if_d;
        logic [DW-1:0] exp_ls_d;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner under contention follows the arbitration policy; otherwise the lone request wins
    function automatic logic [1:0] model_pick(input logic [1:0] req, input logic ptr);
        if (req != 2'b11) return req;
        if (RR) return ptr ? 2'b10 : 2'b01;
        return 2'b10;
    endfunction

    task automatic quiet_inputs();
        if_ARVALID = 1'b0; ls_ARVALID = 1'b0;
        if_RREADY  = 1'b0; ls_RREADY  = 1'b0;
        m_ARREADY  = 1'b0; m_RVALID   = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(posedge clk); #1;
        if (v.sel) begin ls_ARVALID = 1'b1; ls_ARADDR = v.addr; end
        else       begin if_ARVALID = 1'b1; if_ARADDR = v.addr; end
        m_ARREADY = 1'b0; m_RVALID = 1'b0; if_RREADY = 1'b1; ls_RREADY = 1'b1;
        #1 check($sformatf("vec%0d_arready", idx), 64'({ls_ARREADY, if_ARREADY}), v.sel ? 64'd2 : 64'd1);
        @(posedge clk); #1;
        if_ARVALID = 1'b0; ls_ARVALID = 1'b0;
        #1 check($sformatf("vec%0d_m_arvalid", idx), 64'(m_ARVALID), 64'd1);
        check($sformatf("vec%0d_m_araddr", idx), 64'(m_ARADDR), 64'(v.exp_addr));
        repeat (v.ar_wait) begin @(posedge clk); #1; end
        m_ARREADY = 1'b1;
        @(posedge clk); #1;
        m_ARREADY = 1'b0;
        repeat (v.r_wait) begin @(posedge clk); #1; end
        m_RVALID = 1'b1; m_RDATA = v.rdata;
        #1 check($sformatf("vec%0d_if_rvalid", idx), 64'(if_RVALID), 64'(v.exp_if_v));
        check($sformatf("vec%0d_ls_rvalid", idx), 64'(ls_RVALID), 64'(v.exp_ls_v));
        check($sformatf("vec%0d_if_rdata", idx), 64'(if_RDATA), 64'(v.exp_if_d));
        check($sformatf("vec%0d_ls_rdata", idx), 64'(ls_RDATA), 64'(v.exp_ls_d));
        check($sformatf("vec%0d_m_rready", idx), 64'(m_RREADY), 64'd1);
        @(posedge clk); #1;
        #1 check($sformatf("vec%0d_back_idle", idx), 64'({ls_RVALID, if_RVALID, m_RREADY}), 64'd0);
        m_RVALID = 1'b0;
    endtask

    task automatic run_contention();
        logic [AW-1:0] seq[4];
        logic [AW-1:0] exp;
        int n = 0;
        int if_hs = 0;
        do_reset();
        if_ARADDR = 32'h200; ls_ARADDR = 32'h800;
        if_ARVALID = 1'b1; ls_ARVALID = 1'b1;
        m_ARREADY = 1'b1; m_RVALID = 1'b1; m_RDATA = 32'h1234;
        if_RREADY = 1'b1; ls_RREADY = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(posedge clk); #2;
            if (if_ARREADY) if_hs++;
            if (m_ARVALID) begin seq[n] = m_ARADDR; n++; end
        end
        check("contention_count", 64'(n), 64'd4);
        for (int i = 0; i < n; i++) begin
            exp = (RR && (i % 2 == 0)) ? 32'h200 : 32'h800;
            check($sformatf("contention_addr%0d", i), 64'(seq[i]), 64'(exp));
        end
        check("contention_if_grants", 64'(if_hs), RR ? 64'd2 : 64'd0);
        quiet_inputs();
    endtask

    task automatic run_backpressure_and_reset();
        do_reset();
        @(posedge clk); #1;
        if_ARVALID = 1'b1; if_ARADDR = 32'h3000;
        @(posedge clk); #1;
        if_ARVALID = 1'b0;
        ls_ARVALID = 1'b1; ls_ARADDR = 32'h4000;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("slvbp_arvalid%0d", i), 64'(m_ARVALID), 64'd1);
            check($sformatf("slvbp_araddr%0d", i), 64'(m_ARADDR), 64'h3000);
            check($sformatf("slvbp_arready%0d", i), 64'({ls_ARREADY, if_ARREADY}), 64'd0);
            @(posedge clk); #1;
        end
        m_ARREADY = 1'b1;
        @(posedge clk); #1;
        m_ARREADY = 1'b0;
        m_RVALID = 1'b1; m_RDATA = 32'h77; if_RREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("reqbp_m_rready%0d", i), 64'(m_RREADY), 64'd0);
            check($sformatf("reqbp_if_rvalid%0d", i), 64'(if_RVALID), 64'd1);
            check($sformatf("reqbp_ls_arready%0d", i), 64'(ls_ARREADY), 64'd0);
            @(posedge clk); #1;
        end
        if_RREADY = 1'b1;
        #1 check("reqbp_release_m_rready", 64'(m_RREADY), 64'd1);
        check("reqbp_release_rdata", 64'(if_RDATA), 64'h77);
        @(posedge clk); #1;
        #1 check("reqbp_idle_grants_ls", 64'({ls_ARREADY, if_RVALID}), 64'd2);
        @(posedge clk); #1;
        ls_ARVALID = 1'b0; m_RVALID = 1'b0;
        #1 check("rst_addr_pre_arvalid", 64'(m_ARVALID), 64'd1);
        rst_n = 1'b0;
        #1 check("rst_addr_arvalid", 64'(m_ARVALID), 64'd0);
        check("rst_addr_araddr", 64'(m_ARADDR), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        if_ARVALID = 1'b1; if_ARADDR = 32'h5000; m_ARREADY = 1'b1;
        @(posedge clk); #1;
        if_ARVALID = 1'b0;
        @(posedge clk); #1;
        m_ARREADY = 1'b0; m_RVALID = 1'b1; m_RDATA = 32'h99; if_RREADY = 1'b1;
        #1 check("rst_data_pre_rvalid", 64'({if_RVALID, m_RREADY}), 64'd3);
        rst_n = 1'b0;
        #1 check("rst_data_rvalid", 64'({ls_RVALID, if_RVALID}), 64'd0);
        check("rst_data_m_rready", 64'(m_RREADY), 64'd0);
        check("rst_data_rdata", 64'(if_RDATA), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_inputs();
    endtask

    task automatic run_random(input int cycles);
        logic busy = 1'b0, aphase = 1'b0, mgrant = 1'b0, mptr = 1'b0;
        logic if_keep = 1'b0, ls_keep = 1'b0, r_keep = 1'b0;
        logic [AW-1:0] eaddr = '0;
        logic [1:0] erdy;
        logic dphase, e_if_v, e_ls_v, e_mrr;
        logic [DW-1:0] e_if_d, e_ls_d;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (!if_keep) begin if_ARVALID = ($urandom % 3) == 0; if_ARADDR = $urandom; end
            if (!ls_keep) begin ls_ARVALID = ($urandom % 3) == 0; ls_ARADDR = $urandom; end
            if_RREADY = ($urandom % 4) != 0;
            ls_RREADY = ($urandom % 4) != 0;
            m_ARREADY = ($urandom % 2) == 0;
            if (busy && !aphase) begin
                if (!r_keep) begin m_RVALID = ($urandom % 2) == 0; m_RDATA = $urandom; end
            end else begin
                m_RVALID = 1'b0; m_RDATA = $urandom;
            end
            #1;
            erdy   = busy ? 2'b00 : model_pick({ls_ARVALID, if_ARVALID}, mptr);
            dphase = busy && !aphase;
            e_if_v = dphase && !mgrant && m_RVALID;
            e_ls_v = dphase &&  mgrant && m_RVALID;
            e_if_d = (dphase && !mgrant) ? m_RDATA : '0;
            e_ls_d = (dphase &&  mgrant) ? m_RDATA : '0;
            e_mrr  = dphase && (mgrant ? ls_RREADY : if_RREADY);
            check("rnd_arready", 64'({ls_ARREADY, if_ARREADY}), 64'(erdy));
            check("rnd_m_arvalid", 64'(m_ARVALID), 64'(busy && aphase));
            if (busy && aphase) check("rnd_m_araddr", 64'(m_ARADDR), 64'(eaddr));
            check("rnd_rvalid", 64'({ls_RVALID, if_RVALID}), 64'({e_ls_v, e_if_v}));
            check("rnd_if_rdata", 64'(if_RDATA), 64'(e_if_d));
            check("rnd_ls_rdata", 64'(ls_RDATA), 64'(e_ls_d));
            check("rnd_m_rready", 64'(m_RREADY), 64'(e_mrr));
            if_keep = if_ARVALID && !erdy[0];
            ls_keep = ls_ARVALID && !erdy[1];
            r_keep  = 1'b0;
            if (!busy) begin
                if (erdy != 2'b00) begin
                    busy = 1'b1; aphase = 1'b1; mgrant = erdy[1];
                    eaddr = erdy[1] ? ls_ARADDR : if_ARADDR;
                end
            end else if (aphase) begin
                if (m_ARREADY) aphase = 1'b0;
            end else if (m_RVALID && e_mrr) begin
                busy = 1'b0; mptr = ~mgrant;
            end else begin
                r_keep = m_RVALID;
            end
        end
        quiet_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        vecs[0] = '{1'b0, 32'h100,      32'h00000013, 0, 0, 32'h100,      1'b1, 1'b0, 32'h13,       32'h0};
        vecs[1] = '{1'b1, 32'h400,      32'hdeadbeef, 2, 1, 32'h400,      1'b0, 1'b1, 32'h0,        32'hdeadbeef};
        vecs[2] = '{1'b0, 32'hfffffffc, 32'h80000001, 1, 3, 32'hfffffffc, 1'b1, 1'b0, 32'h80000001, 32'h0};
        vecs[3] = '{1'b1, 32'h0,        32'h5a5a5a5a, 0, 0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h5a5a5a5a};

        quiet_inputs();
        #3;
        check("reset_m_arvalid", 64'(m_ARVALID), 64'd0);
        check("reset_m_araddr", 64'(m_ARADDR), 64'd0);
        check("reset_arready", 64'({ls_ARREADY, if_ARREADY}), 64'd0);
        check("reset_rvalid", 64'({ls_RVALID, if_RVALID}), 64'd0);
        check("reset_rdata", 64'({ls_RDATA, if_RDATA}), 64'd0);
        check("reset_m_rready", 64'(m_RREADY), 64'd0);
        do_reset();

        for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);
        run_contention();
        run_backpressure_and_reset();
        run_random(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
